// File: rtl/tx_frame_sched.sv
// Frame scheduler: sequences BPSK/QPSK symbol streams into framed AXIS beats
// for the PSK modulator. Optional inter-frame guard gaps: TX_SCHED_GUARD_EN.
//
// state    | meaning
// IDLE     | no frame in progress, MODE_CTRL sampled every cycle
// BPSK_FRM | forwarding FRAME_LEN symbols from the BPSK source (tuser=1)
// QPSK_FRM | forwarding FRAME_LEN symbols from the QPSK source (tuser=0)
// GUARD    | emitting GUARD_LEN zero beats before the decided frame (optional)
module tx_frame_sched #(
  parameter int BYTES     = 1,
  parameter int FRAME_LEN = 16,
  parameter int LEN_W     = 8,
  parameter int GUARD_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           MODE_CTRL,
  input  logic [BYTES*8-1:0]   s_bpsk_tdata,
  input  logic                 s_bpsk_tvalid,
  output logic                 s_bpsk_tready,
  input  logic [BYTES*8-1:0]   s_qpsk_tdata,
  input  logic                 s_qpsk_tvalid,
  output logic                 s_qpsk_tready,
  output logic [BYTES*8-1:0]   m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 m_tuser,
  output logic                 frame_done
);

  localparam int BITS = BYTES * 8;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BPSK_FRM = 2'd1;
  localparam logic [1:0] QPSK_FRM = 2'd2;
`ifdef TX_SCHED_GUARD_EN
  localparam logic [1:0] GUARD    = 2'd3;
`endif

  localparam logic [BITS-1:0]  BPSK_MASK = BITS'(2);
  localparam logic [BITS-1:0]  QPSK_MASK = BITS'(3);
  localparam logic [LEN_W-1:0] LAST_IDX  = LEN_W'(FRAME_LEN - 1);

  if (BYTES < 1 || FRAME_LEN < 2 || GUARD_LEN < 1 ||
      (longint'(1) << LEN_W) < longint'(FRAME_LEN)) begin : g_param_check
    $error("tx_frame_sched: illegal parameter combination");
  end

`ifdef TX_SCHED_GUARD_EN
  localparam int GUARD_CW = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
  localparam logic [GUARD_CW-1:0] GUARD_LAST = GUARD_CW'(GUARD_LEN - 1);

  logic [GUARD_CW-1:0] guard_cnt;
  logic [1:0]          guard_tgt;
`endif

  logic [1:0]       state;
  logic [LEN_W-1:0] count;
  logic             next_is_bpsk;

  logic ld;
  logic in_bpsk, in_qpsk;
  logic acc_b, acc_q, acc;
  logic last_beat, boundary;
  logic mode_bpsk, mode_qpsk, mode_mix;
  logic mix_bpsk;
  logic [1:0] next_frm;

  assign ld      = !m_tvalid | m_tready;
  assign in_bpsk = (state == BPSK_FRM);
  assign in_qpsk = (state == QPSK_FRM);

  assign s_bpsk_tready = in_bpsk & ld;
  assign s_qpsk_tready = in_qpsk & ld;

  assign acc_b     = s_bpsk_tvalid & s_bpsk_tready;
  assign acc_q     = s_qpsk_tvalid & s_qpsk_tready;
  assign acc       = acc_b | acc_q;
  assign last_beat = (count == LAST_IDX);
  assign boundary  = acc & last_beat;

  assign mode_bpsk = (MODE_CTRL == 4'b0001);
  assign mode_qpsk = (MODE_CTRL == 4'b0010);
  assign mode_mix  = (MODE_CTRL == 4'b0100);

  // From IDLE the MIX phase comes from the register; at a boundary it is the
  // opposite of the frame that is just finishing.
  assign mix_bpsk = (state == IDLE) ? next_is_bpsk : in_qpsk;

  always_comb begin
    next_frm = IDLE;
    if (mode_bpsk)      next_frm = BPSK_FRM;
    else if (mode_qpsk) next_frm = QPSK_FRM;
    else if (mode_mix)  next_frm = mix_bpsk ? BPSK_FRM : QPSK_FRM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tuser    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (ld) begin
        if (acc) begin
          m_tvalid <= 1'b1;
          m_tdata  <= acc_b ? (s_bpsk_tdata & BPSK_MASK) : (s_qpsk_tdata & QPSK_MASK);
          m_tuser  <= acc_b;
          m_tlast  <= last_beat;
`ifdef TX_SCHED_GUARD_EN
        end else if (state == GUARD) begin
          m_tvalid <= 1'b1;
          m_tdata  <= '0;
          m_tuser  <= 1'b1;
          m_tlast  <= 1'b0;
`endif
        end else begin
          m_tvalid <= 1'b0;
        end
      end
      frame_done <= m_tvalid & m_tready & m_tlast;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (acc) begin
      count <= last_beat ? '0 : count + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      next_is_bpsk <= 1'b1;
`ifdef TX_SCHED_GUARD_EN
      guard_cnt    <= '0;
      guard_tgt    <= IDLE;
`endif
    end else begin
      case (state)
        IDLE: begin
          next_is_bpsk <= 1'b1;
          state        <= next_frm;
        end
        BPSK_FRM, QPSK_FRM: begin
          if (boundary) begin
            if (next_frm == IDLE) begin
              next_is_bpsk <= 1'b1;
              state        <= IDLE;
            end else begin
              next_is_bpsk <= in_qpsk;
`ifdef TX_SCHED_GUARD_EN
              state     <= GUARD;
              guard_tgt <= next_frm;
              guard_cnt <= GUARD_LAST;
`else
              state     <= next_frm;
`endif
            end
          end
        end
`ifdef TX_SCHED_GUARD_EN
        GUARD: begin
          // one guard beat leaves per load slot; the last one hands over
          if (ld) begin
            if (guard_cnt == '0) state <= guard_tgt;
            else                 guard_cnt <= guard_cnt - GUARD_CW'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Scoreboard bench for tx_frame_sched with FRAME_LEN=4, GUARD_LEN=2.
// Guard beats are expected only when TX_SCHED_GUARD_EN is defined.
module tb_tx_frame_sched;

  localparam int FL = 4;
  localparam int GL = 2;
`ifdef TX_SCHED_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  localparam logic [3:0] M_BPSK = 4'b0001;
  localparam logic [3:0] M_QPSK = 4'b0010;
  localparam logic [3:0] M_MIX  = 4'b0100;
  localparam logic [3:0] M_STOP = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mode = M_STOP;
  logic [7:0] s_bpsk_tdata, s_qpsk_tdata, m_tdata;
  logic       s_bpsk_tvalid = 1'b1, s_qpsk_tvalid = 1'b1;
  logic       s_bpsk_tready, s_qpsk_tready;
  logic       m_tvalid, m_tlast, m_tuser, frame_done;
  logic       m_tready = 1'b1;

  always #5 clk = ~clk;

  tx_frame_sched #(.BYTES(1), .FRAME_LEN(FL), .LEN_W(3), .GUARD_LEN(GL)) dut (
    .clk(clk), .rst_n(rst_n), .MODE_CTRL(mode),
    .s_bpsk_tdata(s_bpsk_tdata), .s_bpsk_tvalid(s_bpsk_tvalid), .s_bpsk_tready(s_bpsk_tready),
    .s_qpsk_tdata(s_qpsk_tdata), .s_qpsk_tvalid(s_qpsk_tvalid), .s_qpsk_tready(s_qpsk_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       u;
    logic       l;
  } beat_t;

  beat_t exp_q[$];
  int total = 0, bad = 0;
  int popped = 0, frames_seen = 0;
  int eb = 0, eq = 0;
  int idx_b = 0, idx_q = 0;

  // reference symbol streams; unused bits are deliberately non-zero
  function automatic logic [7:0] pat(input int i, input int salt);
    return 8'(((i * 37) + salt) ^ 32'h5A);
  endfunction

  assign s_bpsk_tdata = pat(idx_b, 11);
  assign s_qpsk_tdata = pat(idx_q, 101);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_b <= 0;
      idx_q <= 0;
    end else begin
      if (s_bpsk_tvalid && s_bpsk_tready) idx_b <= idx_b + 1;
      if (s_qpsk_tvalid && s_qpsk_tready) idx_q <= idx_q + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_frame(input bit is_b, input bit gap);
    beat_t e;
    if (gap && GUARD_ON)
      for (int g = 0; g < GL; g++) begin
        e.d = 8'h00; e.u = 1'b1; e.l = 1'b0;
        exp_q.push_back(e);
      end
    for (int k = 0; k < FL; k++) begin
      if (is_b) begin e.d = pat(eb, 11) & 8'h02; eb++; end
      else      begin e.d = pat(eq, 101) & 8'h03; eq++; end
      e.u = is_b;
      e.l = (k == FL - 1);
      exp_q.push_back(e);
    end
  endtask

  // monitor: pops the scoreboard on every handshake, checks frame_done timing
  initial begin : monitor
    beat_t e;
    logic  fd_exp;
    fd_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fd_exp = 1'b0;
      end else begin
        check("frame_done", 32'(frame_done), 32'(fd_exp));
        check("tready_excl", 32'(s_bpsk_tready & s_qpsk_tready), 32'd0);
        fd_exp = 1'b0;
        if (m_tvalid && m_tready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat_extra: got d=%02h u=%0d l=%0d want no beat", m_tdata, m_tuser, m_tlast);
          end else begin
            e = exp_q.pop_front();
            if ({m_tdata, m_tuser, m_tlast} !== e) begin
              bad++;
              $display("FAIL beat[%0d]: got d=%02h u=%0d l=%0d want d=%02h u=%0d l=%0d",
                       popped, m_tdata, m_tuser, m_tlast, e.d, e.u, e.l);
            end
            popped++;
            if (e.l) begin
              frames_seen++;
              fd_exp = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic wait_popped(input int n);
    int cyc = 0;
    while (popped < n && cyc < 300) begin @(posedge clk); #1; cyc++; end
    check("wait_beats", 32'(popped >= n), 32'd1);
  endtask

  task automatic wait_frames(input int n);
    int cyc = 0;
    while (frames_seen < n && cyc < 300) begin @(posedge clk); #1; cyc++; end
    check("wait_frames", 32'(frames_seen >= n), 32'd1);
  endtask

  task automatic start_test(input logic [3:0] m);
    rst_n = 1'b0;
    mode = m;
    m_tready = 1'b1;
    s_bpsk_tvalid = 1'b1;
    s_qpsk_tvalid = 1'b1;
    exp_q.delete();
    popped = 0; frames_seen = 0; eb = 0; eq = 0;
    repeat (2) begin @(posedge clk); #1; end
    check("reset_outputs", 32'({m_tvalid, m_tlast, m_tuser, frame_done,
                                s_bpsk_tready, s_qpsk_tready, m_tdata}), 32'd0);
  endtask

  task automatic end_test(input int stop_at, input int nframes);
    wait_frames(stop_at);
    mode = M_STOP;
    wait_frames(nframes);
    repeat (4) begin @(posedge clk); #1; end
    check("idle_tvalid", 32'(m_tvalid), 32'd0);
    check("idle_tready", 32'({s_bpsk_tready, s_qpsk_tready}), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0] snap;

    // BPSK only: 3 frames, first-beat latency
    start_test(M_BPSK);
    push_frame(1'b1, 1'b0); push_frame(1'b1, 1'b1); push_frame(1'b1, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("latency_early", 32'(m_tvalid), 32'd0);
    @(negedge clk);
    check("latency_first", 32'(m_tvalid), 32'd1);
    end_test(2, 3);

    // MIX: BPSK, QPSK, BPSK
    start_test(M_MIX);
    push_frame(1'b1, 1'b0); push_frame(1'b0, 1'b1); push_frame(1'b1, 1'b1);
    rst_n = 1'b1;
    end_test(2, 3);

    // mode change mid-frame waits for the boundary
    start_test(M_BPSK);
    push_frame(1'b1, 1'b0); push_frame(1'b0, 1'b1);
    rst_n = 1'b1;
    wait_popped(2);
    mode = M_QPSK;
    end_test(1, 2);

    // sink stall then source stall
    start_test(M_BPSK);
    push_frame(1'b1, 1'b0); push_frame(1'b1, 1'b1);
    rst_n = 1'b1;
    wait_popped(2);
    m_tready = 1'b0;
    @(negedge clk);
    snap = {m_tdata, m_tuser, m_tlast};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_hold", 32'({m_tdata, m_tuser, m_tlast}), 32'(snap));
      check("stall_valid", 32'(m_tvalid), 32'd1);
      check("stall_tready", 32'({s_bpsk_tready, s_qpsk_tready}), 32'd0);
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    wait_popped(5);
    s_bpsk_tvalid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    s_bpsk_tvalid = 1'b1;
    end_test(1, 2);

    // stop mode mid-frame: frame completes, then IDLE
    start_test(M_BPSK);
    push_frame(1'b1, 1'b0);
    rst_n = 1'b1;
    wait_popped(1);
    end_test(0, 1);

    // reset mid-frame discards partial frame, restart from count 0
    mode = M_BPSK;
    popped = 0;
    push_frame(1'b1, 1'b0);
    wait_popped(2);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({m_tvalid, m_tlast, m_tuser, frame_done,
                              s_bpsk_tready, s_qpsk_tready, m_tdata}), 32'd0);
    exp_q.delete();
    popped = 0; frames_seen = 0; eb = 0; eq = 0;
    push_frame(1'b1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    wait_popped(1);
    end_test(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
